// File: rtl/change_dispenser.sv
// Coin change dispenser: pays out change in 20- and 10-coins (greedy, twenties first)
// against a hopper handshake, tracking coin inventory and flagging shortage or ack timeout.
module change_dispenser #(
  parameter int INV_W       = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       change_amt,
  input  logic             refill,
  input  logic [INV_W-1:0] refill_10,
  input  logic [INV_W-1:0] refill_20,
  input  logic             coin_ack,
  output logic [1:0]       coin_out,
  output logic             coin_valid,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [INV_W-1:0] inv_10,
  output logic [INV_W-1:0] inv_20
);

  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam int CW = (INV_W > 4) ? INV_W : 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    DISP  = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t           state_r, state_s;
  logic [3:0]       amt_r, amt_s;
  logic [3:0]       rem20_r, rem20_s;
  logic [3:0]       rem10_r, rem10_s;
  logic [TW-1:0]    wait_r, wait_s;
  logic [INV_W-1:0] inv10_r, inv10_s;
  logic [INV_W-1:0] inv20_r, inv20_s;
  logic [1:0]       coin_out_r, coin_out_s;
  logic             valid_r, busy_r, done_r, error_r;
  logic             valid_s, busy_s, done_s, error_s;

  logic [3:0]       half_s, n20_s, n10_s;
  logic [CW-1:0]    inv10_ext_s, inv20_ext_s;
  logic             short_s;

  // Greedy split of the captured amount against the current inventory
  always_comb begin
    half_s      = {1'b0, amt_r[3:1]};
    inv10_ext_s = CW'(inv10_r);
    inv20_ext_s = CW'(inv20_r);
    if (CW'(half_s) <= inv20_ext_s) begin
      n20_s = half_s;
    end else begin
      n20_s = inv20_ext_s[3:0];
    end
    n10_s   = amt_r - {n20_s[2:0], 1'b0};
    short_s = (CW'(n10_s) > inv10_ext_s);
  end

  // Next-state, datapath and next-output decode
  always_comb begin
    state_s = state_r;
    amt_s   = amt_r;
    rem20_s = rem20_r;
    rem10_s = rem10_r;
    wait_s  = wait_r;
    inv10_s = inv10_r;
    inv20_s = inv20_r;
    case (state_r)
      IDLE: begin
        if (refill) begin
          inv10_s = refill_10;
          inv20_s = refill_20;
        end else begin
          inv10_s = inv10_r;
        end
        if (start) begin
          amt_s   = change_amt;
          state_s = CHECK;
        end else begin
          state_s = IDLE;
        end
      end
      CHECK: begin
        if (short_s) begin
          state_s = ERR;
        end else if (amt_r == 4'd0) begin
          state_s = DONE;
        end else begin
          rem20_s = n20_s;
          rem10_s = n10_s;
          wait_s  = TW'(0);
          state_s = DISP;
        end
      end
      DISP: begin
        if (coin_ack) begin
          // Decrements are guarded so a counter can never wrap below zero
          if (rem20_r != 4'd0) begin
            rem20_s = rem20_r - 4'd1;
            if (inv20_r != INV_W'(0)) begin
              inv20_s = inv20_r - INV_W'(1);
            end else begin
              inv20_s = inv20_r;
            end
          end else begin
            rem10_s = (rem10_r != 4'd0) ? (rem10_r - 4'd1) : 4'd0;
            if (inv10_r != INV_W'(0)) begin
              inv10_s = inv10_r - INV_W'(1);
            end else begin
              inv10_s = inv10_r;
            end
          end
          state_s = GAP;
        end else if (wait_r >= TW'(ACK_TIMEOUT - 1)) begin
          state_s = ERR;
        end else begin
          wait_s = wait_r + TW'(1);
        end
      end
      GAP: begin
        wait_s = TW'(0);
        if ((rem20_r != 4'd0) || (rem10_r != 4'd0)) begin
          state_s = DISP;
        end else begin
          state_s = DONE;
        end
      end
      DONE:    state_s = IDLE;
      ERR:     state_s = IDLE;
      default: state_s = IDLE;
    endcase

    valid_s    = (state_s == DISP);
    busy_s     = (state_s != IDLE);
    done_s     = (state_s == DONE);
    error_s    = (state_s == ERR);
    coin_out_s = (valid_s && (rem20_s != 4'd0)) ? 2'b01 : 2'b00;
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      amt_r      <= 4'd0;
      rem20_r    <= 4'd0;
      rem10_r    <= 4'd0;
      wait_r     <= TW'(0);
      inv10_r    <= INV_W'(0);
      inv20_r    <= INV_W'(0);
      coin_out_r <= 2'b00;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      amt_r      <= amt_s;
      rem20_r    <= rem20_s;
      rem10_r    <= rem10_s;
      wait_r     <= wait_s;
      inv10_r    <= inv10_s;
      inv20_r    <= inv20_s;
      coin_out_r <= coin_out_s;
      valid_r    <= valid_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      error_r    <= error_s;
    end
  end

  assign coin_out   = coin_out_r;
  assign coin_valid = valid_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign error      = error_r;
  assign inv_10     = inv10_r;
  assign inv_20     = inv20_r;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus randomized
// transactions checked against an arithmetic model of coin payout and inventory.
module tb_change_dispenser;

  localparam int INV_W = 8;
  localparam int TMO   = 15;

  logic             clk = 1'b0;
  logic             reset, start, refill, coin_ack;
  logic [3:0]       change_amt;
  logic [INV_W-1:0] refill_10, refill_20;
  logic [1:0]       coin_out;
  logic             coin_valid, busy, done, error;
  logic [INV_W-1:0] inv_10, inv_20;

  int checks   = 0;
  int failures = 0;
  int m_inv10  = 0;
  int m_inv20  = 0;

  change_dispenser #(.INV_W(INV_W), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .change_amt(change_amt),
    .refill(refill), .refill_10(refill_10), .refill_20(refill_20),
    .coin_ack(coin_ack), .coin_out(coin_out), .coin_valid(coin_valid),
    .busy(busy), .done(done), .error(error), .inv_10(inv_10), .inv_20(inv_20)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_inv(input string tag);
    chk({tag, ".inv10"}, 32'(inv_10), 32'(m_inv10));
    chk({tag, ".inv20"}, 32'(inv_20), 32'(m_inv20));
  endtask

  // One transaction from the IDLE state. delay = ack-low cycles per coin;
  // timeout_at = index of the coin whose ack is withheld (-1 for none).
  task automatic run_txn(input bit do_refill, input int r10, input int r20,
                         input int amt, input int delay, input int timeout_at);
    int n20, n10, total;
    if (do_refill) begin
      m_inv10 = r10;
      m_inv20 = r20;
    end
    n20   = (amt / 2 < m_inv20) ? amt / 2 : m_inv20;
    n10   = amt - 2 * n20;
    total = n20 + n10;

    start      = 1'b1;
    change_amt = 4'(amt);
    refill     = do_refill;
    refill_10  = INV_W'(r10);
    refill_20  = INV_W'(r20);
    step();
    start      = 1'b0;
    refill     = 1'b0;
    change_amt = 4'($urandom_range(0, 15));
    refill_10  = INV_W'($urandom_range(0, 255));
    coin_ack   = 1'b1;
    chk("check.busy", 32'(busy), 32'd1);
    chk("check.valid", 32'(coin_valid), 32'd0);
    step();
    coin_ack = 1'b0;

    if (n10 > m_inv10) begin
      chk("short.error", 32'(error), 32'd1);
      chk("short.valid", 32'(coin_valid), 32'd0);
      chk_inv("short");
      step();
      chk("short.idle", 32'(busy), 32'd0);
      chk("short.errpulse", 32'(error), 32'd0);
      return;
    end
    if (amt == 0) begin
      chk("zero.done", 32'(done), 32'd1);
      chk("zero.valid", 32'(coin_valid), 32'd0);
      step();
      chk("zero.idle", 32'(busy), 32'd0);
      return;
    end

    for (int i = 0; i < total; i++) begin
      logic [1:0] exp_code;
      exp_code = (i < n20) ? 2'b01 : 2'b00;
      if (i == timeout_at) begin
        for (int c = 0; c < TMO; c++) begin
          chk("tmo.valid", 32'(coin_valid), 32'd1);
          chk("tmo.code", 32'(coin_out), 32'(exp_code));
          start      = 1'($urandom_range(0, 1));
          refill     = 1'($urandom_range(0, 1));
          change_amt = 4'($urandom_range(0, 15));
          step();
        end
        start  = 1'b0;
        refill = 1'b0;
        chk("tmo.error", 32'(error), 32'd1);
        chk("tmo.valid_low", 32'(coin_valid), 32'd0);
        chk_inv("tmo");
        step();
        chk("tmo.idle", 32'(busy), 32'd0);
        return;
      end
      for (int c = 0; c < delay; c++) begin
        chk("wait.valid", 32'(coin_valid), 32'd1);
        chk("wait.code", 32'(coin_out), 32'(exp_code));
        start      = 1'($urandom_range(0, 1));
        refill     = 1'($urandom_range(0, 1));
        refill_20  = INV_W'($urandom_range(0, 255));
        change_amt = 4'($urandom_range(0, 15));
        step();
      end
      start  = 1'b0;
      refill = 1'b0;
      chk("coin.valid", 32'(coin_valid), 32'd1);
      chk("coin.code", 32'(coin_out), 32'(exp_code));
      coin_ack = 1'b1;
      step();
      if (i < n20) m_inv20--; else m_inv10--;
      coin_ack = 1'($urandom_range(0, 1));
      chk("gap.valid", 32'(coin_valid), 32'd0);
      chk("gap.busy", 32'(busy), 32'd1);
      chk_inv("gap");
      step();
      coin_ack = 1'b0;
    end
    chk("end.done", 32'(done), 32'd1);
    chk("end.valid", 32'(coin_valid), 32'd0);
    chk_inv("end");
    step();
    chk("end.idle", 32'(busy), 32'd0);
    chk("end.donepulse", 32'(done), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; refill = 1'b1; coin_ack = 1'b1;
    change_amt = 4'd7; refill_10 = INV_W'(9); refill_20 = INV_W'(9);
    step();
    step();
    chk("rst.valid", 32'(coin_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.error", 32'(error), 32'd0);
    chk("rst.code", 32'(coin_out), 32'd0);
    chk_inv("rst");
    reset = 1'b0; start = 1'b0; refill = 1'b0; coin_ack = 1'b0;
    step();
    chk("idle.busy", 32'(busy), 32'd0);

    run_txn(1'b1, 5, 5, 4, 0, -1);
    run_txn(1'b1, 3, 0, 3, 0, -1);
    run_txn(1'b1, 0, 2, 1, 0, -1);
    run_txn(1'b0, 0, 0, 0, 0, -1);
    run_txn(1'b1, 10, 10, 5, 5, -1);
    run_txn(1'b0, 0, 0, 3, 14, -1);
    run_txn(1'b1, 10, 10, 6, 1, 1);

    // Reset in the middle of a payout
    refill = 1'b1; refill_10 = INV_W'(4); refill_20 = INV_W'(4);
    start = 1'b1; change_amt = 4'd4;
    step();
    refill = 1'b0; start = 1'b0;
    step();
    chk("mid.valid", 32'(coin_valid), 32'd1);
    reset = 1'b1; coin_ack = 1'b1;
    step();
    reset = 1'b0; coin_ack = 1'b0;
    m_inv10 = 0; m_inv20 = 0;
    chk("mrst.valid", 32'(coin_valid), 32'd0);
    chk("mrst.busy", 32'(busy), 32'd0);
    chk_inv("mrst");

    for (int t = 0; t < 25; t++) begin
      bit rf;
      int dly, tmo_at;
      rf     = (t == 0) || ($urandom_range(0, 2) == 0);
      dly    = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3));
      tmo_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2)) : -1;
      run_txn(rf, int'($urandom_range(0, 10)), int'($urandom_range(0, 8)),
              int'($urandom_range(0, 15)), dly, tmo_at);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
